dt_init_unpack: RTL

DT_INIT_UNPACK -- requirements
Module: dt_init_unpack

---
 rtl/dt_pkg.sv | 17 +
 rtl/dt_pix_serializer.sv | 49 ++++
 rtl/dt_init_unpack.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared types and helpers for the bitplane-to-pixel unpacker.
package dt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EMIT,
    S_FIN
  } dt_state_e;

  // Address width for a space of n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dt_pix_serializer.sv
// Holds one source word and presents its bits one at a time in pixel-address order.
module dt_pix_serializer
  import dt_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter bit MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  input  logic [WORD_W-1:0] din,
  output logic              bit_o,
  output logic              last
);

  localparam int IW = addr_w(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [IW-1:0]     idx_q, idx_d;

  // Load restarts the word; advance shifts the consumed bit out.
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load) begin
      sr_d  = din;
      idx_d = '0;
    end else if (adv) begin
      sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
      idx_d = idx_q + IW'(1);
    end
  end

  // Shift register and bit index state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign bit_o = MSB_FIRST ? sr_q[WORD_W-1] : sr_q[0];
  assign last  = (idx_q == IW'(WORD_W - 1));

endmodule

// File: rtl/dt_init_unpack.sv
// Reads a packed 1-bpp image word by word and writes it out as one pixel per address.
module dt_init_unpack
  import dt_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int PIX_W     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       mode_invert,
  input  logic                                       mode_border,
  output logic                                       sti_rd,
  output logic [addr_w(IMG_W*IMG_H/WORD_W)-1:0]      sti_addr,
  input  logic [WORD_W-1:0]                          sti_di,
  output logic                                       res_wr,
  output logic [addr_w(IMG_W*IMG_H)-1:0]             res_addr,
  output logic [PIX_W-1:0]                           res_do,
  input  logic                                       res_ready,
  output logic                                       busy,
  output logic                                       done
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWORD = NPIX / WORD_W;
  localparam int SA_W  = addr_w(NWORD);
  localparam int PA_W  = addr_w(NPIX);
  localparam int RW    = addr_w(IMG_H);
  localparam int CW    = addr_w(IMG_W);

  if ((NPIX % WORD_W) != 0 || IMG_W < 2 || IMG_H < 2 || PIX_W < 1) begin : g_bad_cfg
    $error("dt_init_unpack: image must be a whole number of words, at least 2x2, PIX_W >= 1");
  end

  dt_state_e       state_q, state_d;
  logic [SA_W-1:0] word_q, word_d;
  logic [PA_W-1:0] pix_q, pix_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            inv_q, inv_d;
  logic            bor_q, bor_d;

  logic ser_bit, ser_last, ser_load, ser_adv;
  logic on_border, pix_bit;

  assign ser_load = (state_q == S_LOAD);
  assign ser_adv  = (state_q == S_EMIT) && res_ready;

  dt_pix_serializer #(
    .WORD_W   (WORD_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .load (ser_load),
    .adv  (ser_adv),
    .din  (sti_di),
    .bit_o(ser_bit),
    .last (ser_last)
  );

  assign on_border = (row_q == '0) || (row_q == RW'(IMG_H - 1)) ||
                     (col_q == '0) || (col_q == CW'(IMG_W - 1));
  assign pix_bit   = (ser_bit ^ inv_q) & ~(bor_q & on_border);

  // Sequencer: next state, counters and all bus outputs.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    pix_d    = pix_q;
    row_d    = row_q;
    col_d    = col_q;
    inv_d    = inv_q;
    bor_d    = bor_q;
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_wr   = 1'b0;
    res_addr = '0;
    res_do   = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          inv_d   = mode_invert;
          bor_d   = mode_border;
          word_d  = '0;
          pix_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        sti_rd   = 1'b1;
        sti_addr = word_q;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        busy     = 1'b1;
        res_wr   = 1'b1;
        res_addr = pix_q;
        res_do   = PIX_W'(pix_bit);
        if (res_ready) begin
          pix_d = pix_q + PA_W'(1);
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (ser_last) begin
            if (word_q == SA_W'(NWORD - 1)) begin
              state_d = S_FIN;
            end else begin
              word_d  = word_q + SA_W'(1);
              state_d = S_FETCH;
            end
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and latched modes; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      pix_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      inv_q   <= 1'b0;
      bor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      col_q   <= col_d;
      inv_q   <= inv_d;
      bor_q   <= bor_d;
    end
  end

endmodule
